// File: rtl/ascii_case_stream_if.sv
// Beat-level stream bundle for the ASCII case converter: producer side
// (in_*) and consumer side (out_*) handshakes in one place.
interface ascii_case_stream_if #(
  parameter int LANES = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [8*LANES-1:0]   in_data;
  logic [LANES-1:0]     in_keep;
  logic [1:0]           in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   out_data;
  logic [LANES-1:0]     out_keep;

  // Converter view
  modport slave (
    input  in_valid, in_data, in_keep, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_keep
  );

  // Producer/consumer view
  modport master (
    output in_valid, in_data, in_keep, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_keep
  );
endinterface

// File: rtl/ascii_case_stream.sv
// Multi-lane streaming ASCII case converter with a 2-entry output buffer
// and a saturating count of modified characters.
//
// state   | meaning
// --------+-------------------------------------------
// S_EMPTY | no beat buffered, out_valid low
// S_ONE   | head holds one beat
// S_FULL  | head and tail both hold beats, in_ready low
module ascii_case_stream #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ascii_case_stream_if.slave  bus,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    conv_count
);

  localparam int DW = 8 * LANES;
  localparam int NW = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [LANES-1:0] head_keep_q, head_keep_d, tail_keep_q, tail_keep_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_sum;

  logic [DW-1:0]    conv_data;
  logic [LANES-1:0] is_up, is_lo, flip;
  logic [NW-1:0]    nmod;
  logic             push, pop;

  // in_ready is also gated by rst_n so nothing is accepted while reset is held
  assign bus.in_ready  = rst_n && (state_q != S_FULL);
  assign bus.out_valid = (state_q != S_EMPTY);
  assign bus.out_data  = head_q;
  assign bus.out_keep  = head_keep_q;
  assign conv_count    = cnt_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Per-lane letter classification and bit-5 flip selection
  always_comb begin
    is_up     = '0;
    is_lo     = '0;
    flip      = '0;
    nmod      = '0;
    conv_data = bus.in_data;
    for (int i = 0; i < LANES; i++) begin
      is_up[i] = (bus.in_data[8*i +: 8] >= 8'h41) && (bus.in_data[8*i +: 8] <= 8'h5A);
      is_lo[i] = (bus.in_data[8*i +: 8] >= 8'h61) && (bus.in_data[8*i +: 8] <= 8'h7A);
      case (bus.in_mode)
        2'b01:   flip[i] = bus.in_keep[i] & is_lo[i];
        2'b10:   flip[i] = bus.in_keep[i] & is_up[i];
        2'b11:   flip[i] = bus.in_keep[i] & (is_up[i] | is_lo[i]);
        default: flip[i] = 1'b0;
      endcase
      conv_data[8*i + 5] = bus.in_data[8*i + 5] ^ flip[i];
      nmod = nmod + NW'(flip[i]);
    end
  end

  // Buffer occupancy FSM and head/tail steering; the head always feeds the output
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    head_keep_d = head_keep_q;
    tail_d      = tail_q;
    tail_keep_d = tail_keep_q;
    case (state_q)
      S_EMPTY: begin
        if (push) begin
          head_d      = conv_data;
          head_keep_d = bus.in_keep;
          state_d     = S_ONE;
        end
      end
      S_ONE: begin
        if (push) begin
          if (pop) begin
            head_d      = conv_data;
            head_keep_d = bus.in_keep;
          end else begin
            tail_d      = conv_data;
            tail_keep_d = bus.in_keep;
            state_d     = S_FULL;
          end
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          head_d      = tail_q;
          head_keep_d = tail_keep_q;
          state_d     = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Saturating modified-character counter; clear dominates an accept
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(nmod);
    cnt_d   = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (push) begin
      cnt_d = cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end
  end

  // State, buffer and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      head_q      <= '0;
      head_keep_q <= '0;
      tail_q      <= '0;
      tail_keep_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      head_keep_q <= head_keep_d;
      tail_q      <= tail_d;
      tail_keep_q <= tail_keep_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ascii_case_stream.sv
// Directed bench for ascii_case_stream: scoreboard queue filled at accept,
// drained by an output monitor sampling on the falling edge.
module tb_ascii_case_stream;

  localparam int LANES = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             cnt_clr;
  logic [CNT_W-1:0] conv_count;

  ascii_case_stream_if #(.LANES(LANES)) bus ();

  ascii_case_stream #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cnt_clr    (cnt_clr),
    .conv_count (conv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          cnt_model = 0;
  int          n_out = 0;
  logic [35:0] sb[$];
  logic [35:0] mon_e;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference conversion written as classic toupper/tolower arithmetic
  task automatic model(input logic [31:0] d, input logic [3:0] k, input logic [1:0] m,
                       output logic [31:0] ed, output int en);
    logic [7:0] c;
    bit is_l, is_u;
    ed = d;
    en = 0;
    for (int i = 0; i < 4; i++) begin
      c = d[8*i +: 8];
      is_l = (c >= "a") && (c <= "z");
      is_u = (c >= "A") && (c <= "Z");
      if (k[i]) begin
        if ((m == 2'd1 || m == 2'd3) && is_l) begin c = c - 8'd32; en++; end
        else if ((m == 2'd2 || m == 2'd3) && is_u) begin c = c + 8'd32; en++; end
      end
      ed[8*i +: 8] = c;
    end
  endtask

  task automatic note_accept(input logic [31:0] ed, input logic [3:0] k, input int en);
    sb.push_back({k, ed});
    if (cnt_clr) cnt_model = 0;
    else cnt_model = (cnt_model + en > CMAX) ? CMAX : cnt_model + en;
  endtask

  // Offer one beat (called just after a rising edge) and wait for its accept
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic [1:0] m,
                      input logic [31:0] ed, input int en, output int waits);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_keep  = k;
    bus.in_mode  = m;
    waits = 0;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits > 50) begin
        chk("accept_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    note_accept(ed, k, en);
    bus.in_valid = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic send_m(input logic [31:0] d, input logic [3:0] k, input logic [1:0] m,
                        output int waits);
    logic [31:0] ed;
    int en;
    model(d, k, m, ed, en);
    send(d, k, m, ed, en, waits);
  endtask

  // Output monitor: scoreboard compare, counter compare, hold stability
  always @(negedge clk) begin
    if (rst_n) begin
      chk("conv_count", 64'(conv_count), 64'(cnt_model));
      if (hold_v && bus.out_valid) chk("hold_stable", 64'(bus.out_data), 64'(hold_d));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(mon_e[31:0]));
          chk("out_keep", 64'(bus.out_keep), 64'(mon_e[35:32]));
        end
        n_out++;
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int n0;
    logic [31:0] e1, e3, d1, d2, d3;
    int en1, en2, en3;
    logic [31:0] e2;

    rst_n        = 1'b0;
    cnt_clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_keep  = '0;
    bus.in_mode  = 2'd0;
    bus.out_ready = 1'b1;

    // Reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    end
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_keep", 64'(bus.out_keep), 64'd0);
    chk("rst_conv_count", 64'(conv_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

    // Modes on "a","A","[","z"
    send(32'h7A5B4161, 4'hF, 2'b01, 32'h5A5B4141, 2, w);
    send(32'h7A5B4161, 4'hF, 2'b10, 32'h7A5B6161, 1, w);
    send(32'h7A5B4161, 4'hF, 2'b11, 32'h5A5B6141, 3, w);
    send(32'h7A5B4161, 4'hF, 2'b00, 32'h7A5B4161, 0, w);

    // Boundary and high-bit bytes are never modified
    for (int m = 0; m < 4; m++) begin
      send(32'h407B605B, 4'hF, 2'(m), 32'h407B605B, 0, w);
      send(32'hE1C1FA40, 4'hF, 2'(m), 32'hE1C1FA40, 0, w);
    end

    // Keep mask
    send(32'h61616161, 4'h5, 2'b01, 32'h61416141, 2, w);
    repeat (2) @(posedge clk); #1;
    chk("sb_drained_1", 64'(sb.size()), 64'd0);

    // Backpressure: two accepts then stall, hold beat 1
    bus.out_ready = 1'b0;
    d1 = 32'h64636261; d2 = 32'h44434241; d3 = 32'h21217A41;
    model(d1, 4'hF, 2'b01, e1, en1);
    model(d2, 4'hF, 2'b11, e2, en2);
    model(d3, 4'hF, 2'b10, e3, en3);
    send(d1, 4'hF, 2'b01, e1, en1, w);
    chk("bp_first_no_wait", 64'(w), 64'd0);
    send(d2, 4'hF, 2'b11, e2, en2, w);
    chk("bp_second_no_wait", 64'(w), 64'd0);
    bus.in_valid = 1'b1; bus.in_data = d3; bus.in_keep = 4'hF; bus.in_mode = 2'b10;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      chk("bp_head_beat1", 64'(bus.out_data), 64'(e1));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    n0 = n_out;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_release_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_reopen_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_second_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    note_accept(e3, 4'hF, en3);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_third_valid", 64'(bus.out_valid), 64'd1);
    #1;
    chk("bp_consecutive_pops", 64'(n_out - n0), 64'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_empty_after", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;

    // Streaming 10 random beats with out_ready held high
    n0 = n_out;
    for (int i = 0; i < 10; i++) begin
      send_m($urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), w);
      chk("stream_no_stall", 64'(w), 64'd0);
    end
    @(negedge clk); #1;
    chk("stream_count", 64'(n_out - n0), 64'd10);
    @(posedge clk); #1;

    // Counter saturation
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    cnt_model = 0;
    for (int i = 0; i < 5; i++) send(32'h64636261, 4'hF, 2'b01, 32'h44434241, 4, w);
    @(negedge clk);
    chk("cnt_saturated", 64'(conv_count), 64'd15);
    @(posedge clk); #1;

    // Clear wins over a same-cycle accept
    cnt_clr = 1'b1;
    send(32'h7A7A7A7A, 4'hF, 2'b01, 32'h5A5A5A5A, 4, w);
    @(negedge clk);
    chk("cnt_clr_with_accept", 64'(conv_count), 64'd0);
    @(posedge clk); #1;
    send(32'h7A7A7A7A, 4'hF, 2'b11, 32'h5A5A5A5A, 4, w);
    repeat (2) @(posedge clk); #1;

    // Async reset with two beats buffered
    bus.out_ready = 1'b0;
    send(32'h61626364, 4'hF, 2'b01, 32'h41424344, 4, w);
    send(32'h31323334, 4'hF, 2'b01, 32'h31323334, 0, w);
    #1;
    rst_n = 1'b0;
    sb.delete();
    cnt_model = 0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("midrst_conv_count", 64'(conv_count), 64'd0);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_stale", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(32'h5A7A4161, 4'hF, 2'b11, 32'h7A5A6141, 4, w);
    repeat (3) @(posedge clk); #1;
    chk("sb_drained_end", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ascii_case_stream.md
Name: ascii_case_stream

Overview:
- Streaming, multi-lane ASCII case converter; successor to the combinational single-character toupper gate block.
- Converts LANES characters per beat under a runtime mode (pass/upper/lower/toggle). Only true letters are modified; all other bytes pass unchanged.
- Sits between a byte-stream producer and consumer, with valid/ready handshakes, a 2-entry output buffer, and a saturating count of modified characters.

Parameters:
- LANES, 4, characters per beat; each lane is 8 bits (ASCII), and lane 0 is bits [7:0].
- CNT_W, 16, width of the modified-character counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  8*LANES  input characters.
- in_keep  in  LANES  per-lane byte enable; a lane with keep=0 is forwarded unmodified and not counted.
- in_mode  in  2  mode, sampled with the beat: 00 pass, 01 upper, 10 lower, 11 toggle.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  8*LANES  converted characters.
- out_keep  out  LANES  in_keep carried with the beat.
- cnt_clr  in  1  synchronous clear of conv_count.
- conv_count  out  CNT_W  saturating count of modified characters.

Behaviour:
- Reset (rst_n low, asynchronous): buffer empty, out_valid=0, out_data=0, out_keep=0, conv_count=0, in_ready=0 while held low. The first edge after release sees in_ready=1.
- Letter classification per lane:
  - Upper-case: 0x41..0x5A.
  - Lower-case: 0x61..0x7A.
  - Any other value, including bit7=1, is a non-letter and is never modified in any mode.
- Conversion per lane with keep=1, done by flipping bit 5 only:
  - upper: lower-case letters are converted.
  - lower: upper-case letters are converted.
  - toggle: all letters are converted.
  - pass: nothing is converted.
- Conversion is combinational on the input side. The converted beat is written into a 2-entry FIFO (output buffer).
- Handshake:
  - Accept when in_valid && in_ready. Emit when out_valid && out_ready.
  - in_ready = (occupancy < 2). It depends on registers only, with no combinational path from out_ready.
  - out_valid = (occupancy > 0). out_data, out_keep and out_valid are driven from registers.
  - Latency: a beat accepted at edge N appears on out_data after edge N when the buffer was empty.
  - Zero bubbles: full throughput (1 beat/cycle) is sustained when out_ready is held high.
- Occupancy transitions:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle at occupancy 1: stays 1; the new beat follows the popped one.
  - At occupancy 2: no push is possible (in_ready=0); a pop drops occupancy to 1, and in_ready rises on the next cycle.
  - At occupancy 0: no pop is possible.
- Ordering: strict FIFO order. out_data and out_keep are stable while out_valid=1 and out_ready=0. in_mode is sampled per beat, so a mode change takes effect from the next accepted beat.
- conv_count:
  - On each accept, adds the number of lanes actually modified (0..LANES).
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr=1 forces 0 on that edge; clear wins over a same-cycle increment.
  - Counting happens at accept, not at emit.
- Reset mid-stream: buffered beats are discarded and no partial beat is emitted after release.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release → out_valid=0, conv_count=0, in_ready=1 on the first post-reset cycle.
- Modes, out_ready=1: in_data=0x7A_5B_41_61 ("a","A","[","z"), keep=0xF.
  - mode 01 → 0x5A_5B_41_41, count +2.
  - mode 10 → 0x7A_5B_61_61, count +1.
  - mode 11 → 0x5A_5B_61_41, count +3.
  - mode 00 → unchanged, count +0.
  - Boundary bytes 0x40, 0x5B, 0x60, 0x7B, 0xE1 remain unmodified in every mode.
- Keep mask: in_data=0x61616161, keep=0x5, mode 01 → out_data=0x61416141, out_keep=0x5, count +2.
- Backpressure:
  - Hold out_ready=0 and offer 3 beats → in_ready drops after 2 accepts; out_data stays fixed on beat 1.
  - Release out_ready → beats emerge in order 1, 2, 3 on consecutive cycles.
  - Streaming 10 beats with out_ready=1 → 10 outputs in 10 cycles after the first.
- Counter:
  - With CNT_W=4, feed 5 beats of 4 lower-case letters in mode 01 → conv_count saturates at 15.
  - cnt_clr asserted together with an accept → conv_count=0.
- Async reset mid-operation: with 2 beats buffered, pulse rst_n low between clock edges → out_valid falls immediately; no stale beat appears after release.
